// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with clear, clamped parallel load, wrap or saturate at the limits,
// a one-cycle limit-event pulse and a sticky overflow flag.
module mod_updown_counter #(
    parameter int unsigned     BITS     = 8,
    parameter longint unsigned MODULUS  = 256,
    parameter int unsigned     SATURATE = 0
) (
    input  logic            CLK,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            up,
    input  logic            clear,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            ovf_clr,
    output logic [BITS-1:0] count,
    output logic            at_limit,
    output logic            limit_evt,
    output logic            overflow
);

    localparam int unsigned NW = BITS + 1;
    // Both constants fit in BITS+1 bits because MODULUS <= 2**BITS.
    localparam logic [NW-1:0]   MOD_W   = NW'(MODULUS);
    localparam logic [NW-1:0]   LIMIT_W = NW'(MODULUS - 64'd1);
    localparam logic [BITS-1:0] LIMIT   = LIMIT_W[BITS-1:0];

    if (BITS < 1 || BITS > 32) begin : g_bad_bits
        $error("mod_updown_counter: BITS must be in 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << BITS)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS must be in 2..2**BITS");
    end

    logic [NW-1:0]   count_w;
    logic [NW-1:0]   step_up;
    logic [NW-1:0]   step_dn;
    logic [BITS-1:0] count_nxt;
    logic            evt_nxt;
    logic            ovf_nxt;
    logic            hit;

    assign count_w  = {1'b0, count};
    assign at_limit = up ? (count == LIMIT) : (count == '0);

    // Next state: clear > load > enable > hold; a limit event beats ovf_clr.
    always_comb begin
        count_nxt = count;
        evt_nxt   = 1'b0;
        ovf_nxt   = overflow;
        hit       = 1'b0;
        step_up   = count_w + NW'(1);
        step_dn   = count_w - NW'(1);

        if (clear) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
        end else if (load) begin
            count_nxt = ({1'b0, load_value} > LIMIT_W) ? LIMIT : load_value;
            if (ovf_clr) begin
                ovf_nxt = 1'b0;
            end
        end else begin
            if (ovf_clr) begin
                ovf_nxt = 1'b0;
            end
            if (enable) begin
                if (up) begin
                    if (step_up == MOD_W) begin
                        hit       = 1'b1;
                        count_nxt = (SATURATE != 0) ? LIMIT : '0;
                    end else begin
                        count_nxt = step_up[BITS-1:0];
                    end
                end else begin
                    // Borrow out of the extended subtract marks a step below zero.
                    if (step_dn[NW-1]) begin
                        hit       = 1'b1;
                        count_nxt = (SATURATE != 0) ? '0 : LIMIT;
                    end else begin
                        count_nxt = step_dn[BITS-1:0];
                    end
                end
            end
            if (hit) begin
                evt_nxt = 1'b1;
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            limit_evt <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            count     <= count_nxt;
            limit_evt <= evt_nxt;
            overflow  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench for mod_updown_counter: a wrapping and a saturating MODULUS=10 instance
// share one set of stimulus; expected values are hand-computed constants.
module tb_mod_updown_counter;

    logic       CLK;
    logic       reset_n;
    logic       enable;
    logic       up;
    logic       clear;
    logic       load;
    logic [3:0] load_value;
    logic       ovf_clr;

    logic [3:0] w_count, s_count;
    logic       w_at_limit, s_at_limit;
    logic       w_evt, s_evt;
    logic       w_ovf, s_ovf;

    int checks   = 0;
    int failures = 0;

    mod_updown_counter #(.BITS(4), .MODULUS(10), .SATURATE(0)) u_wrap (
        .CLK(CLK), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
        .count(w_count), .at_limit(w_at_limit), .limit_evt(w_evt), .overflow(w_ovf)
    );

    mod_updown_counter #(.BITS(4), .MODULUS(10), .SATURATE(1)) u_sat (
        .CLK(CLK), .reset_n(reset_n), .enable(enable), .up(up), .clear(clear),
        .load(load), .load_value(load_value), .ovf_clr(ovf_clr),
        .count(s_count), .at_limit(s_at_limit), .limit_evt(s_evt), .overflow(s_ovf)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        enable = 0; up = 1; clear = 0; load = 0; load_value = '0; ovf_clr = 0;
        reset_n = 1;
        #1 reset_n = 0;

        // Reset held while enable toggles
        for (int i = 0; i < 4; i++) begin
            enable = ~enable;
            step();
            check("rst_count", 32'(w_count), 0);
            check("rst_ovf", 32'(w_ovf), 0);
            check("rst_evt", 32'(w_evt), 0);
            check("rst_scount", 32'(s_count), 0);
        end
        reset_n = 1;
        enable  = 0;
        step();
        check("post_rst_hold", 32'(w_count), 0);

        // Wrap up for 12 cycles
        enable = 1; up = 1;
        for (int i = 1; i <= 12; i++) begin
            step();
            check("wrap_up_count", 32'(w_count), 32'(i % 10));
            check("wrap_up_evt", 32'(w_evt), (i == 10) ? 1 : 0);
            check("wrap_up_ovf", 32'(w_ovf), (i >= 10) ? 1 : 0);
            check("wrap_up_atlim", 32'(w_at_limit), (i == 9) ? 1 : 0);
        end
        check("sat_up_count", 32'(s_count), 9);
        check("sat_up_ovf", 32'(s_ovf), 1);

        // clear beats load and enable
        clear = 1; load = 1; load_value = 4'd7; enable = 1;
        step();
        check("prio_count", 32'(w_count), 0);
        check("prio_ovf", 32'(w_ovf), 0);
        check("prio_evt", 32'(w_evt), 0);
        check("prio_scount", 32'(s_count), 0);

        // Wrap down from 0
        clear = 0; load = 0; up = 0;
        #1;
        check("down_atlim0", 32'(w_at_limit), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            check("wrap_dn_count", 32'(w_count), 32'(9 - i));
            check("wrap_dn_evt", 32'(w_evt), (i == 0) ? 1 : 0);
            check("wrap_dn_ovf", 32'(w_ovf), 1);
        end
        check("wrap_dn_atlim", 32'(w_at_limit), 1);
        up = 1;
        #1;
        check("dir_atlim", 32'(w_at_limit), 0);

        // Saturate: load 8 then up four times, then down once
        enable = 0; load = 1; load_value = 4'd8;
        step();
        check("sat_load", 32'(s_count), 8);
        load = 0; enable = 1; up = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("sat_count", 32'(s_count), 9);
            check("sat_evt", 32'(s_evt), (i >= 1) ? 1 : 0);
        end
        up = 0;
        step();
        check("sat_down", 32'(s_count), 8);
        check("sat_down_evt", 32'(s_evt), 0);

        // Load clamp and overflow interplay
        enable = 0; load = 1; load_value = 4'd15;
        step();
        check("clamp_count", 32'(w_count), 9);
        check("clamp_scount", 32'(s_count), 9);
        check("load_keeps_ovf", 32'(w_ovf), 1);
        load = 0; ovf_clr = 1;
        step();
        check("ovf_clr", 32'(w_ovf), 0);
        enable = 1; up = 1;
        step();
        check("set_wins_ovf", 32'(w_ovf), 1);
        check("set_wins_evt", 32'(w_evt), 1);
        check("set_wins_count", 32'(w_count), 0);
        enable = 0;
        step();
        check("ovf_clr2", 32'(w_ovf), 0);
        check("evt_drop", 32'(w_evt), 0);
        ovf_clr = 0;

        // Async reset mid-count at 5
        clear = 1;
        step();
        clear = 0; enable = 1; up = 1;
        for (int i = 0; i < 5; i++) step();
        check("pre_async", 32'(w_count), 5);
        enable = 0;
        #2 reset_n = 0;
        #1;
        check("async_count", 32'(w_count), 0);
        check("async_scount", 32'(s_count), 0);
        step();
        check("async_hold", 32'(w_count), 0);
        #2 reset_n = 1;
        enable = 1;
        step();
        check("resume_count", 32'(w_count), 1);
        check("resume_ovf", 32'(w_ovf), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
